md_unit: RTL and testbench

//  Parametrised multiply/divide unit with HI/LO for the EX stage of the pipelined MIPS core.

---
 rtl/md_unit.sv | 136 +++++++++++++
 tb/tb_md_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO for the EX stage: fixed per-class latency,
// MADD/MSUB accumulate, divide-by-zero leaves HI/LO untouched, optional cancel abort.
module md_unit #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned MUL_LAT         = 5,
  parameter int unsigned DIV_LAT         = 10,
  parameter bit          ABORT_ON_CANCEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic             we,
  input  logic             sel,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned DW      = 2 * WIDTH;
  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CW      = $clog2(MAX_LAT + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic [DW-1:0]    acc, prod, res;
  logic [WIDTH-1:0] quo, rem;
  logic             res_wr;
  logic             accept, mt_write;

  // Result of the requested op, evaluated from operands and HI/LO at the launch edge
  always_comb begin
    acc    = {hi_q, lo_q};
    res_wr = 1'b1;
    if (op[0]) prod = DW'(d1) * DW'(d2);
    else       prod = DW'($signed(d1)) * DW'($signed(d2));

    if (op[0]) begin
      quo = d1 / d2;
      rem = d1 % d2;
    end else if (d1 == MOST_NEG && d2 == '1) begin
      quo = MOST_NEG;
      rem = '0;
    end else begin
      quo = WIDTH'($signed(d1) / $signed(d2));
      rem = WIDTH'($signed(d1) % $signed(d2));
    end

    res = prod;
    if (op[2]) begin
      res = op[1] ? (acc - prod) : (acc + prod);
    end else if (op[1]) begin
      res    = {rem, quo};
      res_wr = (d2 != '0);
    end
  end

  assign accept   = start & ~busy_q & ~cancel;
  assign mt_write = we & ~busy_q & ~cancel & ~start;

  // Launch, countdown/commit, abort and MTHI/MTLO sequencing
  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    if (accept) begin
      pend_hi_d = res[DW-1:WIDTH];
      pend_lo_d = res[WIDTH-1:0];
      pend_wr_d = res_wr;
      cnt_d     = (op[2:1] == 2'b01) ? CW'(DIV_LAT) : CW'(MUL_LAT);
      busy_d    = 1'b1;
    end else if (busy_q) begin
      if (ABORT_ON_CANCEL && cancel) begin
        cnt_d     = '0;
        busy_d    = 1'b0;
        pend_wr_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
    end else if (mt_write) begin
      if (sel) hi_d = d1;
      else     lo_d = d1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_md_unit.sv
// Randomised scoreboard bench for md_unit; a second instance exercises abort-on-cancel.
module tb_md_unit;

  localparam int unsigned ML = 5;
  localparam int unsigned DL = 10;

  logic        clk = 1'b0;
  logic        reset, start, we, sel, cancel, start_a, we_a;
  logic [2:0]  op;
  logic [31:0] d1, d2;
  logic [31:0] hi, lo, hi_a, lo_a;
  logic        busy, done, busy_a, done_a;

  md_unit #(.WIDTH(32), .MUL_LAT(ML), .DIV_LAT(DL), .ABORT_ON_CANCEL(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .d1(d1), .d2(d2),
    .we(we), .sel(sel), .cancel(cancel), .hi(hi), .lo(lo), .busy(busy), .done(done));

  md_unit #(.WIDTH(32), .MUL_LAT(ML), .DIV_LAT(DL), .ABORT_ON_CANCEL(1'b1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .op(op), .d1(d1), .d2(d2),
    .we(we_a), .sel(sel), .cancel(cancel), .hi(hi_a), .lo(lo_a), .busy(busy_a), .done(done_a));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] m_hi, m_lo;

  // Architectural meaning of each op, using plain integer arithmetic
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] h, input logic [31:0] l,
                                output logic [31:0] nh, output logic [31:0] nl);
    logic [63:0] p, acc, r;
    int          sa, sbv, q, rm;
    acc = {h, l};
    sa  = int'(a);
    sbv = int'(b);
    nh  = h;
    nl  = l;
    if (o[0]) p = 64'(a) * 64'(b);
    else      p = longint'(sa) * longint'(sbv);
    case (o)
      3'b000, 3'b001: r = p;
      3'b100, 3'b101: r = acc + p;
      3'b110, 3'b111: r = acc - p;
      default:        r = acc;
    endcase
    if (o[2] || !o[1]) begin
      nh = r[63:32];
      nl = r[31:0];
    end else if (b != 32'd0) begin
      if (o[0]) begin
        nl = a / b;
        nh = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        nl = 32'h8000_0000;
        nh = 32'd0;
      end else begin
        q  = sa / sbv;
        rm = sa - q * sbv;
        nl = 32'(q);
        nh = 32'(rm);
      end
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%h required 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && done) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_done: done=1 at cycle %0d, required done=0 (no op outstanding)", cyc);
        end else begin
          e = sb.pop_front();
          check("done_cycle", 64'(cyc), 64'(e.cyc));
          check("result_hilo", {hi, lo}, {e.hi, e.lo});
        end
      end
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom % 6)
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom % 16);
      default: return 32'($urandom);
    endcase
  endfunction

  // Launch one op; while busy, optionally throw ignored start/we/cancel traffic at it
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit with_we, input bit junk);
    logic [31:0] nh, nl;
    int          lat;
    bit          busy_ok;
    lat     = (o[2:1] == 2'b01) ? int'(DL) : int'(ML);
    busy_ok = 1'b1;
    model(o, a, b, m_hi, m_lo, nh, nl);
    sb.push_back('{cyc: cyc + 1 + lat, hi: nh, lo: nl});
    m_hi = nh;
    m_lo = nl;
    op = o; d1 = a; d2 = b; start = 1'b1; we = with_we; sel = 1'($urandom); cancel = 1'b0;
    tick();
    start = 1'b0; we = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (junk) begin
        start = 1'($urandom); we = 1'($urandom); cancel = 1'($urandom);
        sel = 1'($urandom); op = 3'($urandom); d1 = rnd_val(); d2 = rnd_val();
      end
      tick();
    end
    start = 1'b0; we = 1'b0; cancel = 1'b0;
    check("busy_profile", {62'd0, busy_ok, busy}, 64'b10);
  endtask

  task automatic mt(input bit s, input logic [31:0] v, input bit c);
    start = 1'b0; we = 1'b1; sel = s; d1 = v; cancel = c;
    tick();
    we = 1'b0; cancel = 1'b0;
    if (!c) begin
      if (s) m_hi = v;
      else   m_lo = v;
    end
    check("mt_hilo", {hi, lo}, {m_hi, m_lo});
  endtask

  task automatic cancelled_start();
    start = 1'b1; we = 1'($urandom); sel = 1'($urandom); cancel = 1'b1;
    op = 3'($urandom); d1 = rnd_val(); d2 = rnd_val();
    tick();
    start = 1'b0; we = 1'b0; cancel = 1'b0;
    check("cancel_start", {31'd0, busy, hi, lo}, {31'd0, 1'b0, m_hi, m_lo});
  endtask

  initial begin
    bit done_seen, hold_ok;
    reset = 1'b1; start = 1'b0; we = 1'b0; sel = 1'b0; cancel = 1'b0;
    start_a = 1'b0; we_a = 1'b0; op = 3'd0; d1 = 32'd0; d2 = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    fork
      monitor();
    join_none
    tick(); tick();
    check("reset_state", {hi, lo}, 64'd0);
    check("reset_flags", {62'd0, busy, done}, 64'd0);
    reset = 1'b0;
    tick();

    issue(3'b000, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    check("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    issue(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    check("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(3'b011, 32'd7, 32'd0, 1'b0, 1'b0);
    check("divu_by_zero", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    mt(1'b1, 32'd5, 1'b0);
    mt(1'b0, 32'hFFFF_FFFF, 1'b0);
    issue(3'b101, 32'd1, 32'd1, 1'b0, 1'b0);
    check("maddu_const", {hi, lo}, 64'h0000_0006_0000_0000);
    issue(3'b110, 32'd1, 32'd1, 1'b0, 1'b0);
    check("msub_const", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
    cancelled_start();
    mt(1'b0, 32'h1234_5678, 1'b1);
    issue(3'b000, 32'd3, 32'd4, 1'b1, 1'b1);
    check("start_beats_we", {hi, lo}, 64'd12);
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);

    // Abort instance: cancel on the second busy cycle discards the MULT
    op = 3'b000; d1 = 32'hFFFF_FFFE; d2 = 32'd3; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("abort_busy_drop", {63'd0, busy_a}, 64'd0);
    done_seen = 1'b0; hold_ok = 1'b1;
    for (int i = 0; i < int'(ML) + 2; i++) begin
      if (done_a) done_seen = 1'b1;
      if (hi_a !== 32'd0 || lo_a !== 32'd0) hold_ok = 1'b0;
      tick();
    end
    check("abort_no_done_no_write", {62'd0, done_seen, hold_ok}, 64'b01);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < int'(ML); i++) tick();
    check("abort_inst_commit", {31'd0, done_a, hi_a, lo_a}, {31'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA});

    // Reset on the third cycle of a DIV discards it
    op = 3'b010; d1 = 32'd100; d2 = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
    check("reset_mid_div", {31'd0, busy, hi, lo}, 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < int'(DL) + 3; i++) tick();
    check("post_reset_idle", {31'd0, busy, hi, lo}, 64'd0);

    for (int n = 0; n < 150; n++) begin
      case ($urandom % 8)
        0, 1:    mt(1'($urandom), rnd_val(), 1'b0);
        2:       cancelled_start();
        default: issue(3'($urandom), rnd_val(), rnd_val(), 1'($urandom), 1'b1);
      endcase
    end
    tick(); tick();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
